// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encodings and 8N1 frame constants.
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;   // idle and stop level
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Byte FIFO for the UART transmitter: circular buffer with a count register and registered read data.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a start/data/stop serialiser.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam logic [31:0] CPB_LAST = 32'(CLKS_PER_BIT - 1);

    tx_state_t   state, state_d;
    logic [31:0] clk_cnt, cnt_d;
    logic [2:0]  bit_idx, bit_d;
    logic [7:0]  shift, shift_d;
    logic        serial_d, active_d, done_d;
    logic        bit_end, pop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_Clock),
        .rst_l (i_Rst_L),
        .push  (i_Tx_DV),
        .din   (i_Tx_Byte),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (o_Fifo_Count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_Tx_Ready = !fifo_full;
    assign bit_end    = (clk_cnt == CPB_LAST);

    always_comb begin
        state_d = state;
        cnt_d   = clk_cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = TX_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            TX_START: begin
                // FIFO read data lands the cycle after the pop, so latch it during START.
                shift_d = fifo_dout;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = clk_cnt + 32'd1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_d = TX_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = clk_cnt + 32'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = clk_cnt + 32'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        case (state_d)
            TX_START: serial_d = LINE_START;
            TX_DATA:  serial_d = shift_d[bit_d];
            default:  serial_d = LINE_IDLE;
        endcase
        active_d = (state_d != TX_IDLE);
        done_d   = (state == TX_STOP) && bit_end;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= TX_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_Tx_Serial <= LINE_IDLE;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_d;
            clk_cnt     <= cnt_d;
            bit_idx     <= bit_d;
            shift       <= shift_d;
            o_Tx_Serial <= serial_d;
            o_Tx_Active <= active_d;
            o_Tx_Done   <= done_d;
        end
    end

endmodule
